mm_tile_scheduler: RTL and testbench



---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_tile_scheduler_if.sv | 47 ++++
 rtl/instruction_issuer.sv | 73 +++++++
 rtl/mm_tile_scheduler.sv | 156 +++++++++++++++
 tb/tb_mm_tile_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared types and default widths for the matrix-multiply tile scheduler.
package mm_pkg;

  localparam int unsigned MM_N            = 4;
  localparam int unsigned MM_ADDR_BITS    = 64;
  localparam int unsigned MM_MAX_LEN      = 4096;
  localparam int unsigned MM_COUNTER_BITS = $clog2(MM_MAX_LEN + 1);
  localparam int unsigned MM_REPEATS_BITS = $clog2(MM_MAX_LEN / MM_N + 1);
  localparam int unsigned MM_TILE_BITS    = 2 * MM_REPEATS_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [MM_ADDR_BITS-1:0]    address;
    logic [MM_COUNTER_BITS-1:0] length;
    logic [MM_REPEATS_BITS-1:0] repeats;
  } instr_t;

endpackage

// File: rtl/mm_tile_scheduler_if.sv
// Job, instruction and completion signals of the tile scheduler.
interface mm_tile_scheduler_if;
  import mm_pkg::*;

  logic                       job_valid;
  logic                       job_ready;
  logic [MM_ADDR_BITS-1:0]    a_base_address;
  logic [MM_ADDR_BITS-1:0]    b_base_address;
  logic [MM_COUNTER_BITS-1:0] length_input;
  logic [MM_REPEATS_BITS-1:0] row_tiles_input;
  logic [MM_REPEATS_BITS-1:0] col_tiles_input;

  logic                       a_instruction_valid;
  logic                       a_instruction_ready;
  logic [MM_ADDR_BITS-1:0]    a_address;
  logic [MM_COUNTER_BITS-1:0] a_length;
  logic [MM_REPEATS_BITS-1:0] a_repeats;

  logic                       b_instruction_valid;
  logic                       b_instruction_ready;
  logic [MM_ADDR_BITS-1:0]    b_address;
  logic [MM_COUNTER_BITS-1:0] b_length;
  logic [MM_REPEATS_BITS-1:0] b_repeats;

  logic                       tile_complete;
  logic                       job_done;
  logic                       busy;

  // Scheduler side
  modport master (
    input  job_valid, a_base_address, b_base_address, length_input,
           row_tiles_input, col_tiles_input,
           a_instruction_ready, b_instruction_ready, tile_complete,
    output job_ready, a_instruction_valid, a_address, a_length, a_repeats,
           b_instruction_valid, b_address, b_length, b_repeats, job_done, busy
  );

  // Job source / buffer / output side
  modport slave (
    output job_valid, a_base_address, b_base_address, length_input,
           row_tiles_input, col_tiles_input,
           a_instruction_ready, b_instruction_ready, tile_complete,
    input  job_ready, a_instruction_valid, a_address, a_length, a_repeats,
           b_instruction_valid, b_address, b_length, b_repeats, job_done, busy
  );

endinterface

// File: rtl/instruction_issuer.sv
// Issues `total` buffer instructions, stepping the address by `stride` and
// returning to the base every `wrap` issues (wrap = 0 never returns).
module instruction_issuer
  import mm_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MM_ADDR_BITS-1:0]    base,
  input  logic [MM_ADDR_BITS-1:0]    stride,
  input  logic [MM_COUNTER_BITS-1:0] length,
  input  logic [MM_REPEATS_BITS-1:0] repeats,
  input  logic [MM_REPEATS_BITS-1:0] wrap,
  input  logic [MM_TILE_BITS-1:0]    total,
  input  logic                       ready,
  output logic                       valid,
  output instr_t                     instr,
  output logic                       exhausted_c
);

  logic [MM_ADDR_BITS-1:0]    base_q;
  logic [MM_TILE_BITS-1:0]    total_q;
  logic [MM_TILE_BITS-1:0]    issued_q;
  logic [MM_REPEATS_BITS-1:0] wrap_q;
  logic [MM_REPEATS_BITS-1:0] wrap_cnt_q;
  logic [MM_REPEATS_BITS-1:0] wrap_cnt_next;
  logic                       exhausted_q;
  logic                       fire;
  logic                       last;

  assign fire          = valid && ready;
  assign last          = fire && ((issued_q + MM_TILE_BITS'(1)) == total_q);
  assign wrap_cnt_next = wrap_cnt_q + MM_REPEATS_BITS'(1);
  // Exhaustion is visible in the cycle of the final handshake.
  assign exhausted_c   = exhausted_q || last;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b0;
      instr       <= '0;
      base_q      <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      wrap_q      <= '0;
      wrap_cnt_q  <= '0;
      exhausted_q <= 1'b1;
    end else if (start) begin
      valid         <= 1'b1;
      instr.address <= base;
      instr.length  <= length;
      instr.repeats <= repeats;
      base_q        <= base;
      total_q       <= total;
      issued_q      <= '0;
      wrap_q        <= wrap;
      wrap_cnt_q    <= '0;
      exhausted_q   <= 1'b0;
    end else if (fire) begin
      issued_q <= issued_q + MM_TILE_BITS'(1);
      if (last) begin
        valid       <= 1'b0;
        exhausted_q <= 1'b1;
      end else if ((wrap_q != '0) && (wrap_cnt_next == wrap_q)) begin
        instr.address <= base_q;
        wrap_cnt_q    <= '0;
      end else begin
        instr.address <= instr.address + stride;
        wrap_cnt_q    <= wrap_cnt_next;
      end
    end
  end

endmodule

// File: rtl/mm_tile_scheduler.sv
// Job-level controller: splits a matrix product into N x N output tiles,
// issues A/B buffer instructions and reports job completion.
module mm_tile_scheduler
  import mm_pkg::*;
#(
  parameter int unsigned N                    = MM_N,
  parameter int unsigned MEMORY_ADDRESS_BITS  = MM_ADDR_BITS,
  parameter int unsigned MAX_MATRIX_LENGTH    = MM_MAX_LEN,
  parameter int unsigned COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int unsigned REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1),
  parameter int unsigned TILE_COUNT_BITS      = 2 * REPEATS_COUNTER_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  mm_tile_scheduler_if.master  bus
);

  state_e state_q;
  state_e state_d;

  logic [MEMORY_ADDRESS_BITS-1:0] stride_q;
  logic [TILE_COUNT_BITS-1:0]     total_tiles_q;
  logic [TILE_COUNT_BITS-1:0]     completed_q;
  logic [TILE_COUNT_BITS-1:0]     tiles_c;
  logic [TILE_COUNT_BITS-1:0]     completed_next_c;

  logic   accept_c;
  logic   zero_job_c;
  logic   start_c;
  logic   counting_c;
  logic   all_done_c;
  logic   a_exhausted_c;
  logic   b_exhausted_c;
  logic   a_valid;
  logic   b_valid;
  instr_t a_instr;
  instr_t b_instr;

  logic job_ready_d, busy_d, job_done_d;
  logic job_ready_q, busy_q, job_done_q;

  assign accept_c   = (state_q == IDLE) && bus.job_valid;
  assign zero_job_c = (bus.length_input == COUNTER_BITS'(0))
                   || (bus.row_tiles_input == REPEATS_COUNTER_BITS'(0))
                   || (bus.col_tiles_input == REPEATS_COUNTER_BITS'(0));
  assign start_c    = accept_c && !zero_job_c;
  assign tiles_c    = TILE_COUNT_BITS'(bus.row_tiles_input) * TILE_COUNT_BITS'(bus.col_tiles_input);

  // Completions only count while a job is in flight.
  assign counting_c       = bus.tile_complete && ((state_q == RUN) || (state_q == DRAIN));
  assign completed_next_c = completed_q + TILE_COUNT_BITS'(counting_c);
  assign all_done_c       = (completed_next_c == total_tiles_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept_c) state_d = zero_job_c ? DONE : RUN;
      RUN:   if (a_exhausted_c && b_exhausted_c) state_d = all_done_c ? DONE : DRAIN;
      DRAIN: if (all_done_c) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    job_ready_d = 1'b0;
    busy_d      = 1'b1;
    job_done_d  = 1'b0;
    case (state_d)
      IDLE: begin
        job_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      DONE:    job_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      job_ready_q <= job_ready_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
    end
  end

  // Job registers; the stride is the only multiply on the address path.
  always_ff @(posedge clk) begin
    if (reset) begin
      stride_q      <= '0;
      total_tiles_q <= '0;
      completed_q   <= '0;
    end else if (accept_c) begin
      stride_q      <= MEMORY_ADDRESS_BITS'(bus.length_input) * MEMORY_ADDRESS_BITS'(N);
      total_tiles_q <= tiles_c;
      completed_q   <= '0;
    end else if (counting_c) begin
      completed_q   <= completed_next_c;
    end
  end

  instruction_issuer u_a_issuer (
    .clk         (clk),
    .reset       (reset),
    .start       (start_c),
    .base        (bus.a_base_address),
    .stride      (stride_q),
    .length      (bus.length_input),
    .repeats     (bus.col_tiles_input),
    .wrap        (MM_REPEATS_BITS'(0)),
    .total       (MM_TILE_BITS'(bus.row_tiles_input)),
    .ready       (bus.a_instruction_ready),
    .valid       (a_valid),
    .instr       (a_instr),
    .exhausted_c (a_exhausted_c)
  );

  instruction_issuer u_b_issuer (
    .clk         (clk),
    .reset       (reset),
    .start       (start_c),
    .base        (bus.b_base_address),
    .stride      (stride_q),
    .length      (bus.length_input),
    .repeats     (MM_REPEATS_BITS'(1)),
    .wrap        (bus.col_tiles_input),
    .total       (tiles_c),
    .ready       (bus.b_instruction_ready),
    .valid       (b_valid),
    .instr       (b_instr),
    .exhausted_c (b_exhausted_c)
  );

  assign bus.job_ready           = job_ready_q;
  assign bus.busy                = busy_q;
  assign bus.job_done            = job_done_q;
  assign bus.a_instruction_valid = a_valid;
  assign bus.a_address           = a_instr.address;
  assign bus.a_length            = a_instr.length;
  assign bus.a_repeats           = a_instr.repeats;
  assign bus.b_instruction_valid = b_valid;
  assign bus.b_address           = b_instr.address;
  assign bus.b_length            = b_instr.length;
  assign bus.b_repeats           = b_instr.repeats;

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Self-checking bench for mm_tile_scheduler: directed job table, reset and
// idle-pulse sequences, and randomized jobs against a queue-based model.
module tb_mm_tile_scheduler;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mm_tile_scheduler_if bus ();

  mm_tile_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] ab;
    logic [63:0] bb;
    int          k;
    int          rows;
    int          cols;
    int          rdy;
    int          cpl;
    int          a_stall;
    int          exp_a_n;
    int          exp_b_n;
    logic [63:0] exp_a_last;
    logic [63:0] exp_b_last;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Runs one job; expected instruction streams come from the address rules.
  task automatic run_job(input logic [63:0] ab, input logic [63:0] bb,
                         input int k, input int rows, input int cols,
                         input int rdy_pct, input int cpl_pct, input int a_stall,
                         output int a_n, output int b_n,
                         output logic [63:0] a_last, output logic [63:0] b_last);
    logic [63:0] stride;
    logic [63:0] ea[$];
    logic [63:0] eb[$];
    logic [63:0] exp_addr;
    logic [63:0] pa_addr, pb_addr;
    logic [MM_COUNTER_BITS-1:0] pa_len, pb_len;
    logic [MM_REPEATS_BITS-1:0] pa_rep, pb_rep;
    logic zero, a_rdy, b_rdy;
    logic a_stall_q, b_stall_q, a_fired_q, b_fired_q;
    int tot, pending, cyc, done_cyc, last_evt;

    zero   = (k == 0) || (rows == 0) || (cols == 0);
    tot    = zero ? 0 : rows * cols;
    stride = 64'(k) * 64'(4);
    if (!zero) begin
      for (int i = 0; i < rows; i++) ea.push_back(ab + 64'(i) * stride);
      for (int j = 0; j < tot; j++)  eb.push_back(bb + 64'(j % cols) * stride);
    end
    a_n = 0; b_n = 0; a_last = '0; b_last = '0;

    check("job_ready_idle", 64'(bus.job_ready), 64'(1));
    bus.job_valid       = 1'b1;
    bus.a_base_address  = ab;
    bus.b_base_address  = bb;
    bus.length_input    = MM_COUNTER_BITS'(k);
    bus.row_tiles_input = MM_REPEATS_BITS'(rows);
    bus.col_tiles_input = MM_REPEATS_BITS'(cols);
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'(1));
    check("a_valid_first", 64'(bus.a_instruction_valid), 64'(!zero));
    check("b_valid_first", 64'(bus.b_instruction_valid), 64'(!zero));
    check("job_done_first", 64'(bus.job_done), 64'(zero));

    pending = 0; cyc = 0; done_cyc = -1; last_evt = -1;
    a_stall_q = 1'b0; b_stall_q = 1'b0; a_fired_q = 1'b0; b_fired_q = 1'b0;
    pa_addr = '0; pb_addr = '0; pa_len = '0; pb_len = '0; pa_rep = '0; pb_rep = '0;
    while (cyc < 2000 && done_cyc < 0) begin
      if (a_stall_q) begin
        check("a_hold_valid", 64'(bus.a_instruction_valid), 64'(1));
        check("a_hold_addr", bus.a_address, pa_addr);
        check("a_hold_len", 64'(bus.a_length), 64'(pa_len));
        check("a_hold_rep", 64'(bus.a_repeats), 64'(pa_rep));
      end
      if (b_stall_q) begin
        check("b_hold_valid", 64'(bus.b_instruction_valid), 64'(1));
        check("b_hold_addr", bus.b_address, pb_addr);
        check("b_hold_len", 64'(bus.b_length), 64'(pb_len));
        check("b_hold_rep", 64'(bus.b_repeats), 64'(pb_rep));
      end
      if (a_fired_q && ea.size() > 0) check("a_back_to_back", 64'(bus.a_instruction_valid), 64'(1));
      if (b_fired_q && eb.size() > 0) check("b_back_to_back", 64'(bus.b_instruction_valid), 64'(1));
      if (ea.size() == 0) check("a_extra_valid", 64'(bus.a_instruction_valid), 64'(0));
      if (eb.size() == 0) check("b_extra_valid", 64'(bus.b_instruction_valid), 64'(0));

      if (bus.job_done) begin
        done_cyc = cyc;
      end else begin
        check("job_ready_busy", 64'(bus.job_ready), 64'(0));
        a_rdy = (cyc >= a_stall) && ($urandom_range(99) < rdy_pct);
        b_rdy = ($urandom_range(99) < rdy_pct);
        bus.a_instruction_ready = a_rdy;
        bus.b_instruction_ready = b_rdy;
        a_fired_q = bus.a_instruction_valid && a_rdy;
        b_fired_q = bus.b_instruction_valid && b_rdy;
        a_stall_q = bus.a_instruction_valid && !a_rdy;
        b_stall_q = bus.b_instruction_valid && !b_rdy;
        pa_addr = bus.a_address; pa_len = bus.a_length; pa_rep = bus.a_repeats;
        pb_addr = bus.b_address; pb_len = bus.b_length; pb_rep = bus.b_repeats;
        if (a_fired_q && ea.size() > 0) begin
          exp_addr = ea.pop_front();
          check("a_address", bus.a_address, exp_addr);
          check("a_length", 64'(bus.a_length), 64'(k));
          check("a_repeats", 64'(bus.a_repeats), 64'(cols));
          a_n++; a_last = bus.a_address; last_evt = cyc;
        end
        if (b_fired_q && eb.size() > 0) begin
          exp_addr = eb.pop_front();
          check("b_address", bus.b_address, exp_addr);
          check("b_length", 64'(bus.b_length), 64'(k));
          check("b_repeats", 64'(bus.b_repeats), 64'(1));
          b_n++; b_last = bus.b_address; last_evt = cyc;
          pending++;
        end
        if (pending > 0 && $urandom_range(99) < cpl_pct) begin
          bus.tile_complete = 1'b1;
          pending--;
          last_evt = cyc;
        end
        @(posedge clk); #1;
        bus.tile_complete = 1'b0;
        cyc++;
      end
    end

    if (done_cyc < 0) begin
      check("job_done_timeout", 64'(bus.job_done), 64'(1));
    end else begin
      check("done_latency", 64'(done_cyc), zero ? 64'(0) : 64'(last_evt + 1));
      check("a_all_issued", 64'(ea.size()), 64'(0));
      check("b_all_issued", 64'(eb.size()), 64'(0));
      check("busy_at_done", 64'(bus.busy), 64'(1));
      check("ready_at_done", 64'(bus.job_ready), 64'(0));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(bus.job_done), 64'(0));
      check("ready_after_done", 64'(bus.job_ready), 64'(1));
      check("busy_after_done", 64'(bus.busy), 64'(0));
    end
    bus.a_instruction_ready = 1'b0;
    bus.b_instruction_ready = 1'b0;
  endtask

  initial begin
    vec_t        tbl[6];
    int          a_n, b_n;
    logic [63:0] a_last, b_last;

    tbl[0] = '{64'h1000, 64'h2000, 8, 2, 3, 100, 100, 0, 2, 6, 64'h1020, 64'h2040};
    tbl[1] = '{64'h1000, 64'h2000, 8, 2, 3, 100,  60, 5, 2, 6, 64'h1020, 64'h2040};
    tbl[2] = '{64'h1000, 64'h2000, 8, 0, 3, 100, 100, 0, 0, 0, 64'h0,    64'h0};
    tbl[3] = '{64'h1000, 64'h2000, 0, 2, 2, 100, 100, 0, 0, 0, 64'h0,    64'h0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE0, 4, 3, 2, 70, 50, 0,
               3, 6, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0};
    tbl[5] = '{64'h1000, 64'h2000, 8, 2, 0, 100, 100, 0, 0, 0, 64'h0,    64'h0};

    reset = 1'b1;
    bus.job_valid = 1'b0;
    bus.a_base_address = '0;
    bus.b_base_address = '0;
    bus.length_input = '0;
    bus.row_tiles_input = '0;
    bus.col_tiles_input = '0;
    bus.a_instruction_ready = 1'b0;
    bus.b_instruction_ready = 1'b0;
    bus.tile_complete = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", 64'(bus.job_ready), 64'(1));
    check("rst_a_valid", 64'(bus.a_instruction_valid), 64'(0));
    check("rst_b_valid", 64'(bus.b_instruction_valid), 64'(0));
    check("rst_a_address", bus.a_address, 64'(0));
    check("rst_b_address", bus.b_address, 64'(0));
    check("rst_a_length", 64'(bus.a_length), 64'(0));
    check("rst_b_repeats", 64'(bus.b_repeats), 64'(0));
    check("rst_job_done", 64'(bus.job_done), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      run_job(tbl[v].ab, tbl[v].bb, tbl[v].k, tbl[v].rows, tbl[v].cols,
              tbl[v].rdy, tbl[v].cpl, tbl[v].a_stall, a_n, b_n, a_last, b_last);
      check("tbl_a_count", 64'(a_n), 64'(tbl[v].exp_a_n));
      check("tbl_b_count", 64'(b_n), 64'(tbl[v].exp_b_n));
      check("tbl_a_last", a_last, tbl[v].exp_a_last);
      check("tbl_b_last", b_last, tbl[v].exp_b_last);
      @(posedge clk); #1;
    end

    // Reset in RUN after two B issues.
    bus.a_instruction_ready = 1'b1;
    bus.b_instruction_ready = 1'b1;
    bus.job_valid       = 1'b1;
    bus.a_base_address  = 64'h1000;
    bus.b_base_address  = 64'h2000;
    bus.length_input    = MM_COUNTER_BITS'(8);
    bus.row_tiles_input = MM_REPEATS_BITS'(2);
    bus.col_tiles_input = MM_REPEATS_BITS'(3);
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    check("mid_b_first", bus.b_address, 64'h2000);
    @(posedge clk); #1;
    check("mid_b_second", bus.b_address, 64'h2020);
    @(posedge clk); #1;
    check("mid_b_third", bus.b_address, 64'h2040);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.a_instruction_ready = 1'b0;
    bus.b_instruction_ready = 1'b0;
    check("mid_rst_a_valid", 64'(bus.a_instruction_valid), 64'(0));
    check("mid_rst_b_valid", 64'(bus.b_instruction_valid), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_job_ready", 64'(bus.job_ready), 64'(1));
    run_job(64'h1000, 64'h2000, 8, 2, 3, 100, 100, 0, a_n, b_n, a_last, b_last);
    check("post_rst_b_count", 64'(b_n), 64'(6));
    @(posedge clk); #1;

    // Stray completions in IDLE, then a 1x1 job completing with its B handshake.
    bus.tile_complete = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_pulse_done", 64'(bus.job_done), 64'(0));
      check("idle_pulse_busy", 64'(bus.busy), 64'(0));
    end
    bus.tile_complete = 1'b0;
    run_job(64'h40, 64'h80, 1, 1, 1, 100, 100, 0, a_n, b_n, a_last, b_last);
    check("one_a_last", a_last, 64'h40);
    check("one_b_last", b_last, 64'h80);
    @(posedge clk); #1;

    for (int r = 0; r < 8; r++) begin
      run_job({$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(20, 1)), int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
              int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), int'($urandom_range(3, 0)),
              a_n, b_n, a_last, b_last);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
